// File: rtl/fp_addsub_issue.sv
// Operand-issue stage ahead of the combinational FP adder: folds subtract into b's sign,
// orders operands by magnitude, pre-classifies specials, and issues through a 2-entry skid buffer.
module fp_addsub_issue #(
  parameter int NEXP = 8,
  parameter int NSIG = 23,
  parameter int TAGW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NEXP+NSIG:0]   in_a,
  input  logic [NEXP+NSIG:0]   in_b,
  input  logic                 in_op,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NEXP+NSIG:0]   out_a,
  output logic [NEXP+NSIG:0]   out_b,
  output logic                 out_swap,
  output logic [2:0]           out_special,
  output logic [TAGW-1:0]      out_tag
);

  localparam int W = NEXP + NSIG + 1;

  typedef enum logic [2:0] {
    SPC_NORMAL  = 3'd0,
    SPC_NAN     = 3'd1,
    SPC_INVALID = 3'd2,
    SPC_INF     = 3'd3,
    SPC_ZERO    = 3'd4
  } special_e;

  typedef struct packed {
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            swap;
    special_e        special;
    logic [TAGW-1:0] tag;
  } item_t;

  // Input-side pre-processing
  logic [W-1:0]    b_eff;
  logic [NEXP-1:0] exp_a, exp_b;
  logic [NSIG-1:0] frac_a, frac_b;
  logic            a_nan, b_nan, a_snan, b_snan, a_qnan, b_qnan, a_inf, b_inf;
  item_t           pre;

  assign b_eff  = {in_b[W-1] ^ in_op, in_b[W-2:0]};
  assign exp_a  = in_a[W-2 -: NEXP];
  assign exp_b  = in_b[W-2 -: NEXP];
  assign frac_a = in_a[NSIG-1:0];
  assign frac_b = in_b[NSIG-1:0];

  assign a_nan  = (&exp_a) && (|frac_a);
  assign b_nan  = (&exp_b) && (|frac_b);
  assign a_snan = a_nan && !frac_a[NSIG-1];
  assign b_snan = b_nan && !frac_b[NSIG-1];
  assign a_qnan = a_nan && frac_a[NSIG-1];
  assign b_qnan = b_nan && frac_b[NSIG-1];
  assign a_inf  = (&exp_a) && !(|frac_a);
  assign b_inf  = (&exp_b) && !(|frac_b);

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pre         = '0;
    pre.tag     = in_tag;
    pre.swap    = in_a[W-2:0] < in_b[W-2:0];
    if (pre.swap) begin
      pre.a = b_eff;
      pre.b = in_a;
    end else begin
      pre.a = in_a;
      pre.b = b_eff;
    end
    // Priority order: invalid, NaN propagate, infinity, zero/denormal pair
    if (a_snan || b_snan || (a_inf && b_inf && (in_a[W-1] != b_eff[W-1])))
      pre.special = SPC_INVALID;
    else if (a_qnan || b_qnan)
      pre.special = SPC_NAN;
    else if (a_inf || b_inf)
      pre.special = SPC_INF;
    else if ((exp_a == '0) && (exp_b == '0))
      pre.special = SPC_ZERO;
    else
      pre.special = SPC_NORMAL;
  end

  // Skid buffer: M drives the outputs, S only fills while M is stalled
  item_t m_q, s_q, m_d, s_d;
  logic  m_valid_q, s_valid_q, m_valid_d, s_valid_d;
  logic  ready_q;
  logic  accept, issue;

  assign accept = in_valid && ready_q;
  assign issue  = m_valid_q && out_ready;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (issue && s_valid_q) begin
      // ready_q is low whenever S is full, so no accept can collide here
      m_d       = s_q;
      s_valid_d = 1'b0;
    end else if (accept && (!m_valid_q || issue)) begin
      m_d       = pre;
      m_valid_d = 1'b1;
    end else if (accept) begin
      s_d       = pre;
      s_valid_d = 1'b1;
    end else if (issue) begin
      m_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      ready_q   <= 1'b1;
      // NOTE: data registers are reset too, because the outputs must read zero out of reset.
      m_q       <= '0;
      s_q       <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      ready_q   <= !s_valid_d;
      m_q       <= m_d;
      s_q       <= s_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = m_valid_q;
  assign out_a       = m_q.a;
  assign out_b       = m_q.b;
  assign out_swap    = m_q.swap;
  assign out_special = m_q.special;
  assign out_tag     = m_q.tag;

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Scoreboard bench for fp_addsub_issue: directed vectors push expectations at acceptance,
// a negedge monitor pops and compares every issued pair.
module tb_fp_addsub_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic        out_swap;
  logic [2:0]  out_special;
  logic [3:0]  out_tag;

  fp_addsub_issue #(.NEXP(8), .NSIG(23), .TAGW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_swap    (out_swap),
    .out_special (out_special),
    .out_tag     (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        swap;
    logic [2:0]  sp;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   stalls      = 0;
  int   cycle       = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on every output transfer, and hold-stability under stall
  exp_t         mon_e;
  logic         stall_prev = 1'b0;
  logic [127:0] snap_prev;
  logic [127:0] snap_cur;

  always @(negedge clk) begin
    snap_cur = {out_a, out_b, out_swap, out_special, out_tag};
    if (rst_n) begin
      if (stall_prev && out_valid)
        check("hold_stable", snap_cur, snap_prev);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_issue: got tag %0h, expected no output", out_tag);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("issue_tag%0d", mon_e.tag), snap_cur,
                {mon_e.a, mon_e.b, mon_e.swap, mon_e.sp, mon_e.tag});
        end
      end
      stall_prev = out_valid && !out_ready;
      snap_prev  = snap_cur;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Drive one operand pair; expectation is queued on the cycle it is accepted
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [3:0] tag, input logic [31:0] ea, input logic [31:0] eb,
                      input logic es, input logic [2:0] esp);
    int n;
    exp_t e;
    in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      n++;
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: tag %0h in_ready stayed %b, expected 1", tag, in_ready);
    end else begin
      e.a = ea; e.b = eb; e.swap = es; e.sp = esp; e.tag = tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        op;
    logic [31:0] ea, eb;
    logic        es;
    logic [2:0]  esp;
  } vec_t;

  vec_t vecs[12];
  exp_t e3;
  int   t0;

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h3F800000, 1'b1, 3'd0};
    vecs[1]  = '{32'h40000000, 32'h3F800000, 1'b1, 32'h40000000, 32'hBF800000, 1'b0, 3'd0};
    vecs[2]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7F800000, 32'hFF800000, 1'b0, 3'd2};
    vecs[3]  = '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FA00000, 32'h3F800000, 1'b0, 3'd2};
    vecs[4]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 32'h3F800000, 1'b0, 3'd1};
    vecs[5]  = '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 32'h40000000, 1'b0, 3'd3};
    vecs[6]  = '{32'h00000000, 32'h80000001, 1'b0, 32'h80000001, 32'h00000000, 1'b1, 3'd4};
    vecs[7]  = '{32'h7FC00000, 32'h7F800001, 1'b0, 32'h7FC00000, 32'h7F800001, 1'b0, 3'd2};
    vecs[8]  = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 32'h7F800000, 1'b0, 3'd3};
    vecs[9]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h3F800000, 32'hBF800000, 1'b0, 3'd0};
    vecs[10] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hC0000000, 32'h3F800000, 1'b1, 3'd0};
    vecs[11] = '{32'h7F800000, 32'hFFC00000, 1'b0, 32'hFFC00000, 32'h7F800000, 1'b1, 3'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", {out_a, out_b, out_swap, out_special, out_tag}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-cycle latency into a free output register
    send(32'h3F800000, 32'h40000000, 1'b0, 4'h1, 32'h40000000, 32'h3F800000, 1'b1, 3'd0);
    @(negedge clk);
    check("latency_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    drain();

    // Directed operand / special-case table
    foreach (vecs[i])
      send(vecs[i].a, vecs[i].b, vecs[i].op, 4'(i), vecs[i].ea, vecs[i].eb, vecs[i].es, vecs[i].esp);
    drain();

    // Backpressure: M and S fill, third item is held off
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0, 4'h1, 32'h40000000, 32'h3F800000, 1'b1, 3'd0);
    send(32'h3F800000, 32'h40000000, 1'b0, 4'h2, 32'h40000000, 32'h3F800000, 1'b1, 3'd0);
    in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0; in_tag = 4'h3; in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_m_holds_tag1", {out_valid, out_tag}, {1'b1, 4'h1});
    @(negedge clk);
    check("bp_in_ready_still_low", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_seq_tag1", {out_valid, out_tag}, {1'b1, 4'h1});
    check("bp_ready_before_release", in_ready, 0);
    @(negedge clk);
    check("bp_seq_tag2", {out_valid, out_tag}, {1'b1, 4'h2});
    check("bp_ready_returns", in_ready, 1);
    e3.a = 32'h40000000; e3.b = 32'h3F800000; e3.swap = 1'b1; e3.sp = 3'd0; e3.tag = 4'h3;
    exp_q.push_back(e3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_seq_tag3", {out_valid, out_tag}, {1'b1, 4'h3});
    @(posedge clk);
    #1;
    drain();

    // Streaming: one transfer per cycle with no stall
    stalls = 0;
    t0 = cycle;
    for (int i = 0; i < 8; i++)
      send(32'h40000000, 32'h3F800000, 1'b1, 4'(i), 32'h40000000, 32'hBF800000, 1'b0, 3'd0);
    check("stream_no_stall", stalls, 0);
    check("stream_cycles", cycle - t0, 8);
    drain();

    // Asynchronous reset with M and S both full
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0, 4'h5, 32'h40000000, 32'h3F800000, 1'b1, 3'd0);
    send(32'h3F800000, 32'h40000000, 1'b0, 4'h6, 32'h40000000, 32'h3F800000, 1'b1, 3'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("no_stale_issue", out_valid, 0);
    @(posedge clk);
    #1;
    send(32'h00000001, 32'h00000002, 1'b0, 4'h9, 32'h00000002, 32'h00000001, 1'b1, 3'd4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
